// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared encodings for the memory-access stage:
//   - write-back result select (WB_in_M[1:0])
//   - memory operation (Memory_in_M)
//   - access FSM state type
//   - sel_result(): write-back result mux shared by the M/WB and forward paths
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_ZPAD = 2'b10;
  localparam logic [1:0] SEL_PC1  = 2'b11;

  localparam logic [1:0] MEM_RD = 2'b10;
  localparam logic [1:0] MEM_WR = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [15:0] sel_result(
    input logic [1:0]  sel,
    input logic [15:0] alu,
    input logic [15:0] mem,
    input logic [15:0] zpad,
    input logic [15:0] pc1
  );
    logic [15:0] res;
    case (sel)
      SEL_ALU:  res = alu;
      SEL_MEM:  res = mem;
      SEL_ZPAD: res = zpad;
      SEL_PC1:  res = pc1;
      default:  res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// M/WB pipeline register with bubble insertion.
//   clock, reset : clock and synchronous active-high reset
//   i_done       : stage completes this cycle (no stall)
//   i_kill       : completing instruction retires as bubble (abort / illegal)
//   i_wb, i_result, i_dest, i_valid : values to capture
//   o_wb, o_result, o_dest, o_valid : registered M/WB outputs
// -----------------------------------------------------------------------------
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_done,
  input  logic        i_kill,
  input  logic [2:0]  i_wb,
  input  logic [15:0] i_result,
  input  logic [2:0]  i_dest,
  input  logic        i_valid,
  output logic [2:0]  o_wb,
  output logic [15:0] o_result,
  output logic [2:0]  o_dest,
  output logic        o_valid
);

  logic [2:0]  r_wb;
  logic [15:0] r_result;
  logic [2:0]  r_dest;
  logic        r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb     <= 3'b000;
      r_result <= 16'h0000;
      r_dest   <= 3'b000;
      r_valid  <= 1'b0;
    end else if (!i_done) begin
      // Stalled: the instruction stays in M, downstream sees a full bubble.
      r_wb     <= 3'b000;
      r_result <= 16'h0000;
      r_dest   <= 3'b000;
      r_valid  <= 1'b0;
    end else begin
      // A killed instruction still moves on but can never write back.
      r_wb     <= i_kill ? 3'b000 : i_wb;
      r_result <= i_result;
      r_dest   <= i_dest;
      r_valid  <= i_kill ? 1'b0 : i_valid;
    end
  end

  assign o_wb     = r_wb;
  assign o_result = r_result;
  assign o_dest   = r_dest;
  assign o_valid  = r_valid;

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access stage: issues data-memory loads/stores over a req/ready
// handshake with a bounded wait, stalls upstream while an access is
// outstanding, selects the write-back value, registers it into M/WB and
// offers a same-cycle forwarding path to EX.
//   Inputs : clock, reset, *_in_M (EX/M register), dmem_ready, dmem_rdata
//   Outputs: dmem_req/we/addr/wdata, mem_stall, mem_fault (sticky timeout),
//            mem_illegal, fwd_en/dest/data, *_out_M_WB (M/WB register)
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] PC_plus1_in_M,
  input  logic [2:0]  WB_in_M,
  input  logic [1:0]  Memory_in_M,
  input  logic [15:0] Memory_data_write_in_M,
  input  logic [15:0] ALU_in_M,
  input  logic [15:0] Zero_pad_in_M,
  input  logic [2:0]  Dest_in_M,
  input  logic        Valid_in_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [15:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        mem_illegal,
  output logic        fwd_en,
  output logic [2:0]  fwd_dest,
  output logic [15:0] fwd_data,
  output logic [2:0]  WB_out_M_WB,
  output logic [15:0] Result_out_M_WB,
  output logic [2:0]  Dest_out_M_WB,
  output logic        Valid_out_M_WB
);

  // Last wait count before the access is given up.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_fault;

  logic        w_memop;
  logic        w_illegal;
  logic        w_abort;
  logic        w_stall;
  logic        w_done;
  logic [15:0] w_result;

  assign w_memop   = Valid_in_M & ((Memory_in_M == MEM_RD) | (Memory_in_M == MEM_WR));
  assign w_illegal = Valid_in_M & (Memory_in_M == 2'b11);
  assign w_abort   = (r_state == WAIT) & (r_wait_cnt == LP_LAST) & ~dmem_ready;
  assign w_stall   = w_memop & ~dmem_ready & ~w_abort;
  assign w_done    = ~w_stall;

  assign w_result = sel_result(WB_in_M[1:0], ALU_in_M, dmem_rdata,
                               Zero_pad_in_M, PC_plus1_in_M);

  assign dmem_req   = w_memop & ~w_abort;
  assign dmem_we    = Memory_in_M[0];
  assign dmem_addr  = ALU_in_M;
  assign dmem_wdata = Memory_data_write_in_M;

  assign mem_stall   = w_stall;
  assign mem_fault   = r_fault;
  assign mem_illegal = w_illegal;

  assign fwd_en   = Valid_in_M & WB_in_M[2] & w_done & ~w_abort & ~w_illegal;
  assign fwd_dest = Dest_in_M;
  assign fwd_data = w_result;

  // The IDLE cycle of a stalled request counts as wait cycle 0, so the
  // request is abandoned after TIMEOUT_CYCLES-1 stalled cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memop && !dmem_ready) begin
            r_state    <= WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            r_state    <= IDLE;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == LP_LAST) begin
            r_state    <= IDLE;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clock    (clock),
    .reset    (reset),
    .i_done   (w_done),
    .i_kill   (w_abort | w_illegal),
    .i_wb     (WB_in_M),
    .i_result (w_result),
    .i_dest   (Dest_in_M),
    .i_valid  (Valid_in_M),
    .o_wb     (WB_out_M_WB),
    .o_result (Result_out_M_WB),
    .o_dest   (Dest_out_M_WB),
    .o_valid  (Valid_out_M_WB)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage with TIMEOUT_CYCLES = 4. Inputs change
// 1 time unit after posedge; combinational outputs are sampled at negedge,
// registered outputs 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] PC_plus1_in_M;
  logic [2:0]  WB_in_M;
  logic [1:0]  Memory_in_M;
  logic [15:0] Memory_data_write_in_M;
  logic [15:0] ALU_in_M;
  logic [15:0] Zero_pad_in_M;
  logic [2:0]  Dest_in_M;
  logic        Valid_in_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ready;
  logic [15:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_fault;
  logic        mem_illegal;
  logic        fwd_en;
  logic [2:0]  fwd_dest;
  logic [15:0] fwd_data;
  logic [2:0]  WB_out_M_WB;
  logic [15:0] Result_out_M_WB;
  logic [2:0]  Dest_out_M_WB;
  logic        Valid_out_M_WB;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .PC_plus1_in_M          (PC_plus1_in_M),
    .WB_in_M                (WB_in_M),
    .Memory_in_M            (Memory_in_M),
    .Memory_data_write_in_M (Memory_data_write_in_M),
    .ALU_in_M               (ALU_in_M),
    .Zero_pad_in_M          (Zero_pad_in_M),
    .Dest_in_M              (Dest_in_M),
    .Valid_in_M             (Valid_in_M),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_ready             (dmem_ready),
    .dmem_rdata             (dmem_rdata),
    .mem_stall              (mem_stall),
    .mem_fault              (mem_fault),
    .mem_illegal            (mem_illegal),
    .fwd_en                 (fwd_en),
    .fwd_dest               (fwd_dest),
    .fwd_data               (fwd_data),
    .WB_out_M_WB            (WB_out_M_WB),
    .Result_out_M_WB        (Result_out_M_WB),
    .Dest_out_M_WB          (Dest_out_M_WB),
    .Valid_out_M_WB         (Valid_out_M_WB)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_nop();
    PC_plus1_in_M          = 16'h0000;
    WB_in_M                = 3'b000;
    Memory_in_M            = 2'b00;
    Memory_data_write_in_M = 16'h0000;
    ALU_in_M               = 16'h0000;
    Zero_pad_in_M          = 16'h0000;
    Dest_in_M              = 3'd0;
    Valid_in_M             = 1'b0;
    dmem_ready             = 1'b0;
    dmem_rdata             = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_nop();
    tick();
    tick();
    n_checks++;
    if (Valid_out_M_WB !== 1'b0) begin
      $display("FAIL reset_valid: got %b expected 0", Valid_out_M_WB); n_errors++;
    end
    n_checks++;
    if (Result_out_M_WB !== 16'h0000 || WB_out_M_WB !== 3'b000 || Dest_out_M_WB !== 3'd0) begin
      $display("FAIL reset_mwb: got res=%h wb=%b dest=%0d expected 0/000/0",
               Result_out_M_WB, WB_out_M_WB, Dest_out_M_WB); n_errors++;
    end
    n_checks++;
    if (mem_fault !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      $display("FAIL reset_ctrl: got fault=%b req=%b stall=%b expected 0/0/0",
               mem_fault, dmem_req, mem_stall); n_errors++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    logic [2:0]  wb_v   [3] = '{3'b100, 3'b110, 3'b111};
    logic [15:0] exp_v  [3] = '{16'h1234, 16'h00FF, 16'h0101};
    logic [2:0]  dest_v [3] = '{3'd5, 3'd3, 3'd7};
    for (int i = 0; i < 3; i++) begin
      set_nop();
      Valid_in_M    = 1'b1;
      WB_in_M       = wb_v[i];
      ALU_in_M      = 16'h1234;
      Zero_pad_in_M = 16'h00FF;
      PC_plus1_in_M = 16'h0101;
      Dest_in_M     = dest_v[i];
      dmem_ready    = 1'b1;   // ignored: no request
      @(negedge clock);
      n_checks++;
      if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
        $display("FAIL alu_noreq[%0d]: got req=%b stall=%b expected 0/0", i, dmem_req, mem_stall);
        n_errors++;
      end
      n_checks++;
      if (fwd_en !== 1'b1 || fwd_data !== exp_v[i] || fwd_dest !== dest_v[i]) begin
        $display("FAIL alu_fwd[%0d]: got en=%b data=%h dest=%0d expected 1/%h/%0d",
                 i, fwd_en, fwd_data, fwd_dest, exp_v[i], dest_v[i]); n_errors++;
      end
      tick();
      n_checks++;
      if (Result_out_M_WB !== exp_v[i] || Dest_out_M_WB !== dest_v[i] ||
          Valid_out_M_WB !== 1'b1 || WB_out_M_WB !== wb_v[i]) begin
        $display("FAIL alu_mwb[%0d]: got res=%h dest=%0d v=%b wb=%b expected %h/%0d/1/%b",
                 i, Result_out_M_WB, Dest_out_M_WB, Valid_out_M_WB, WB_out_M_WB,
                 exp_v[i], dest_v[i], wb_v[i]); n_errors++;
      end
    end
    set_nop();
  endtask

  task automatic test_load_zero_wait();
    set_nop();
    Valid_in_M  = 1'b1;
    Memory_in_M = MEM_RD;
    WB_in_M     = 3'b101;
    ALU_in_M    = 16'h0040;
    Dest_in_M   = 3'd2;
    dmem_ready  = 1'b1;
    dmem_rdata  = 16'hBEEF;
    @(negedge clock);
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0040 || mem_stall !== 1'b0) begin
      $display("FAIL load_req: got req=%b we=%b addr=%h stall=%b expected 1/0/0040/0",
               dmem_req, dmem_we, dmem_addr, mem_stall); n_errors++;
    end
    n_checks++;
    if (fwd_en !== 1'b1 || fwd_data !== 16'hBEEF) begin
      $display("FAIL load_fwd: got en=%b data=%h expected 1/beef", fwd_en, fwd_data); n_errors++;
    end
    tick();
    n_checks++;
    if (Result_out_M_WB !== 16'hBEEF || Valid_out_M_WB !== 1'b1 || Dest_out_M_WB !== 3'd2) begin
      $display("FAIL load_mwb: got res=%h v=%b dest=%0d expected beef/1/2",
               Result_out_M_WB, Valid_out_M_WB, Dest_out_M_WB); n_errors++;
    end
    set_nop();
  endtask

  task automatic test_store_wait();
    set_nop();
    Valid_in_M             = 1'b1;
    Memory_in_M            = MEM_WR;
    WB_in_M                = 3'b000;
    ALU_in_M               = 16'h0010;
    Memory_data_write_in_M = 16'h00AA;
    Dest_in_M              = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (mem_stall !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b1 ||
          dmem_wdata !== 16'h00AA || fwd_en !== 1'b0) begin
        $display("FAIL store_stall[%0d]: got stall=%b req=%b we=%b wdata=%h fwd=%b expected 1/1/1/00aa/0",
                 i, mem_stall, dmem_req, dmem_we, dmem_wdata, fwd_en); n_errors++;
      end
      tick();
      n_checks++;
      if (Valid_out_M_WB !== 1'b0 || Result_out_M_WB !== 16'h0000) begin
        $display("FAIL store_bubble[%0d]: got v=%b res=%h expected 0/0000",
                 i, Valid_out_M_WB, Result_out_M_WB); n_errors++;
      end
    end
    dmem_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (mem_stall !== 1'b0) begin
      $display("FAIL store_release: got stall=%b expected 0", mem_stall); n_errors++;
    end
    tick();
    n_checks++;
    if (Valid_out_M_WB !== 1'b1 || Result_out_M_WB !== 16'h0010 || WB_out_M_WB !== 3'b000) begin
      $display("FAIL store_retire: got v=%b res=%h wb=%b expected 1/0010/000",
               Valid_out_M_WB, Result_out_M_WB, WB_out_M_WB); n_errors++;
    end
    set_nop();
    tick();
    n_checks++;
    if (Valid_out_M_WB !== 1'b0) begin
      $display("FAIL store_one_edge: got v=%b expected 0", Valid_out_M_WB); n_errors++;
    end
  endtask

  task automatic test_timeout();
    set_nop();
    Valid_in_M  = 1'b1;
    Memory_in_M = MEM_RD;
    WB_in_M     = 3'b101;
    ALU_in_M    = 16'h0080;
    Dest_in_M   = 3'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (mem_stall !== 1'b1 || mem_fault !== 1'b0) begin
        $display("FAIL timeout_stall[%0d]: got stall=%b fault=%b expected 1/0",
                 i, mem_stall, mem_fault); n_errors++;
      end
      tick();
    end
    @(negedge clock);
    n_checks++;
    if (mem_stall !== 1'b0 || dmem_req !== 1'b0 || fwd_en !== 1'b0) begin
      $display("FAIL timeout_abort: got stall=%b req=%b fwd=%b expected 0/0/0",
               mem_stall, dmem_req, fwd_en); n_errors++;
    end
    tick();
    n_checks++;
    if (mem_fault !== 1'b1 || Valid_out_M_WB !== 1'b0 || WB_out_M_WB !== 3'b000) begin
      $display("FAIL timeout_retire: got fault=%b v=%b wb=%b expected 1/0/000",
               mem_fault, Valid_out_M_WB, WB_out_M_WB); n_errors++;
    end
    n_checks++;
    if (dut.r_state !== IDLE) begin
      $display("FAIL timeout_idle: got state=%0d expected %0d", dut.r_state, IDLE); n_errors++;
    end
    set_nop();
    tick();
    tick();
    n_checks++;
    if (mem_fault !== 1'b1) begin
      $display("FAIL fault_sticky: got %b expected 1", mem_fault); n_errors++;
    end
  endtask

  task automatic test_illegal();
    set_nop();
    Valid_in_M  = 1'b1;
    Memory_in_M = 2'b11;
    WB_in_M     = 3'b100;
    ALU_in_M    = 16'h7777;
    dmem_ready  = 1'b1;
    @(negedge clock);
    n_checks++;
    if (mem_illegal !== 1'b1 || dmem_req !== 1'b0 || fwd_en !== 1'b0 || mem_stall !== 1'b0) begin
      $display("FAIL illegal_comb: got ill=%b req=%b fwd=%b stall=%b expected 1/0/0/0",
               mem_illegal, dmem_req, fwd_en, mem_stall); n_errors++;
    end
    tick();
    n_checks++;
    if (Valid_out_M_WB !== 1'b0 || WB_out_M_WB !== 3'b000 || dut.r_state !== IDLE) begin
      $display("FAIL illegal_mwb: got v=%b wb=%b state=%0d expected 0/000/0",
               Valid_out_M_WB, WB_out_M_WB, dut.r_state); n_errors++;
    end
    Valid_in_M = 1'b0;
    @(negedge clock);
    n_checks++;
    if (mem_illegal !== 1'b0 || dmem_req !== 1'b0) begin
      $display("FAIL illegal_invalid: got ill=%b req=%b expected 0/0", mem_illegal, dmem_req);
      n_errors++;
    end
    tick();
    set_nop();
  endtask

  task automatic test_reset_mid_wait();
    set_nop();
    Valid_in_M  = 1'b1;
    Memory_in_M = MEM_RD;
    WB_in_M     = 3'b101;
    ALU_in_M    = 16'h0020;
    Dest_in_M   = 3'd6;
    tick();          // IDLE -> WAIT (cnt 1)
    tick();          // now in the 2nd WAIT cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (Valid_out_M_WB !== 1'b0 || Result_out_M_WB !== 16'h0000 || mem_fault !== 1'b0) begin
      $display("FAIL rstwait_out: got v=%b res=%h fault=%b expected 0/0000/0",
               Valid_out_M_WB, Result_out_M_WB, mem_fault); n_errors++;
    end
    n_checks++;
    if (dut.r_state !== IDLE || dut.r_wait_cnt !== 8'd0) begin
      $display("FAIL rstwait_fsm: got state=%0d cnt=%0d expected 0/0",
               dut.r_state, dut.r_wait_cnt); n_errors++;
    end
    // New load, one wait cycle then ready.
    @(negedge clock);
    n_checks++;
    if (mem_stall !== 1'b1) begin
      $display("FAIL rstwait_newstall: got %b expected 1", mem_stall); n_errors++;
    end
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 16'h5A5A;
    @(negedge clock);
    n_checks++;
    if (mem_stall !== 1'b0 || fwd_data !== 16'h5A5A) begin
      $display("FAIL rstwait_ready: got stall=%b fwd=%h expected 0/5a5a", mem_stall, fwd_data);
      n_errors++;
    end
    tick();
    n_checks++;
    if (Valid_out_M_WB !== 1'b1 || Result_out_M_WB !== 16'h5A5A || Dest_out_M_WB !== 3'd6) begin
      $display("FAIL rstwait_load: got v=%b res=%h dest=%0d expected 1/5a5a/6",
               Valid_out_M_WB, Result_out_M_WB, Dest_out_M_WB); n_errors++;
    end
    set_nop();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 6-stage pipeline. It consumes the EX/M register outputs, performs the data-memory load or store over a ready/req handshake with a bounded wait, and stalls the upstream stages while the access is outstanding. It selects the write-back result and registers it into the M/WB pipeline register. It also exposes a same-cycle forwarding path to EX.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a request may wait for dmem_ready before abort; legal range 2..255.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- PC_plus1_in_M  in  16  PC+1 of instruction in M.
- WB_in_M  in  3  [2] reg write enable, [1:0] result select: 00 ALU, 01 load data, 10 zero-pad, 11 PC+1.
- Memory_in_M  in  2  [1] read, [0] write.
- Memory_data_write_in_M  in  16  store data.
- ALU_in_M  in  16  ALU result / memory address.
- Zero_pad_in_M  in  16  zero-padded immediate.
- Dest_in_M  in  3  destination register.
- Valid_in_M  in  1  instruction valid.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  16  = ALU_in_M.
- dmem_wdata  out  16  = Memory_data_write_in_M.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  16  load data, valid when dmem_ready.
- mem_stall  out  1  upstream must hold EX/M and earlier.
- mem_fault  out  1  sticky timeout flag.
- mem_illegal  out  1  one-cycle pulse on Memory_in_M = 11.
- fwd_en  out  1  forwarding data valid.
- fwd_dest  out  3  forwarding destination.
- fwd_data  out  16  forwarding data.
- WB_out_M_WB  out  3  registered WB control.
- Result_out_M_WB  out  16  registered write-back value.
- Dest_out_M_WB  out  3  registered destination.
- Valid_out_M_WB  out  1  registered valid.

## Operation
- memop = Valid_in_M & (Memory_in_M == 10 or 01). Memory_in_M = 11 with Valid_in_M: no access, mem_illegal = 1, instruction retires as bubble. Valid_in_M = 0: no access regardless of Memory_in_M.
- dmem_req = memop & ~abort. dmem_we = Memory_in_M[0]. All combinational. Request fields are stable while stalled because upstream holds.
- FSM:
  - IDLE: memop & ~dmem_ready -> WAIT, wait_cnt = 1. Otherwise stay.
  - WAIT: dmem_ready -> IDLE. Else if wait_cnt == TIMEOUT_CYCLES-1, abort this cycle -> IDLE. Else wait_cnt++.
- abort = (state == WAIT) & (wait_cnt == TIMEOUT_CYCLES-1) & ~dmem_ready.
- mem_stall = memop & ~dmem_ready & ~abort.
- done = ~mem_stall.
- Result select per WB_in_M[1:0]: ALU_in_M / dmem_rdata / Zero_pad_in_M / PC_plus1_in_M.
- On a done edge, M/WB takes WB_in_M, the result, Dest_in_M and Valid_in_M. Exceptions:
  - Abort or illegal: Valid_out = 0, WB_out = 000.
  - Stall: a bubble is inserted (all M/WB outputs 0).
- mem_fault is set on abort and cleared only by reset.
- Forwarding: fwd_en = Valid_in_M & WB_in_M[2] & done & ~abort & ~illegal. fwd_dest = Dest_in_M. fwd_data = selected result.

## Timing
- Reset: all M/WB outputs 0, state IDLE, wait_cnt 0, mem_fault 0. Combinational outputs follow the inputs. A reset mid-WAIT drops to IDLE at that edge, and the access is abandoned.
- Non-memory instruction: 1-cycle latency into M/WB.
- Zero-wait access (dmem_ready in the request cycle): no stall, 1-cycle latency.
- N-cycle wait: mem_stall is high for N cycles, and the result registers on the edge ending the ready cycle.
- Timeout: stall lasts TIMEOUT_CYCLES-1 cycles, then the bubble retires.
- dmem_ready while dmem_req = 0 is ignored.

## Structure
- Shared package holds:
  - WB select encodings: SEL_ALU, SEL_MEM, SEL_ZPAD, SEL_PC1.
  - Memory op encodings: MEM_RD = 10, MEM_WR = 01.
  - FSM state type {IDLE, WAIT}.
- A sub-module mem_wb_reg holds the M/WB pipeline register with bubble insert. The FSM, counter and select logic live in the top module.

## Test plan
- ALU op, WB = 100, ALU_in = 0x1234, Dest = 5 -> next edge: Result_out = 0x1234, Dest_out = 5, Valid_out = 1, no dmem_req.
- Load at 0x0040, ready same cycle, rdata = 0xBEEF, WB = 101 -> no stall, Result_out = 0xBEEF; fwd_data = 0xBEEF in the request cycle.
- Store of 0x00AA at 0x0010, ready after 3 cycles -> mem_stall high 3 cycles, dmem_we = 1, bubbles in M/WB, then Valid_out = 1 for one edge.
- TIMEOUT_CYCLES = 4, ready never asserted -> stall for 3 cycles, then mem_fault = 1 (sticky), Valid_out = 0, FSM back in IDLE.
- Memory_in = 11, Valid = 1 -> mem_illegal pulse, no dmem_req, Valid_out = 0. Same with Valid = 0 -> no pulse.
- Reset asserted during the 2nd WAIT cycle -> next edge: M/WB outputs 0, mem_fault 0, IDLE; a new load proceeds normally.
